// File: rtl/read_bpm_link_gen.sv
// read_bpm_link_gen
// Parses Aurora AXI-stream BPM link packets of one header word plus NWORDS
// payload words. Publishes a validated payload vector with a per-packet status
// code, and keeps saturating per-status counters for diagnostics.
module read_bpm_link_gen #(
    parameter int          NWORDS = 3,
    parameter logic [15:0] MAGIC  = 16'hA5BE,
    parameter int          CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    input  logic                     crc_valid,
    input  logic                     crc_pass,
    input  logic                     inhibit,
    input  logic                     clr_counts,
    output logic                     out_valid,
    output logic [16+32*NWORDS-1:0]  out_data,
    output logic                     stat_valid,
    output logic [1:0]               stat_code,
    output logic [CNT_W-1:0]         cnt_success,
    output logic [CNT_W-1:0]         cnt_bad_hdr,
    output logic [CNT_W-1:0]         cnt_bad_size,
    output logic [CNT_W-1:0]         cnt_bad_pkt
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    // Shadow holds the header and every payload word except the final one;
    // the final word goes straight from the bus into out_data.
    localparam int PRE_W = 16 + 32 * (NWORDS - 1);

    localparam logic [1:0] ST_SUCCESS  = 2'd0;
    localparam logic [1:0] ST_BAD_HDR  = 2'd1;
    localparam logic [1:0] ST_BAD_SIZE = 2'd2;
    localparam logic [1:0] ST_BAD_PKT  = 2'd3;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_PAYLOAD = 2'd1,
        S_FLUSH   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [PRE_W-1:0]   shadow;

    logic               ev_valid;
    logic [1:0]         ev_code;
    logic [31:0]        ev_final;
    logic               hdr_ok;

    // Saturating increment: all-ones is sticky.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign hdr_ok   = (s_tdata[31:16] == MAGIC);
    // Bit 30 of the final word carries no payload meaning and is forced low.
    assign ev_final = {s_tdata[31], 1'b0, s_tdata[29:0]};

    // Decode the status event (if any) produced by the current beat.
    always_comb begin
        ev_valid = 1'b0;
        ev_code  = ST_SUCCESS;
        if (s_tvalid) begin
            case (state)
                S_HEADER: begin
                    if (s_tlast) begin
                        ev_valid = 1'b1;
                        ev_code  = ST_BAD_SIZE;
                    end else if (!hdr_ok) begin
                        ev_valid = 1'b1;
                        ev_code  = ST_BAD_HDR;
                    end
                end
                S_PAYLOAD: begin
                    if (idx != LAST_IDX) begin
                        if (s_tlast) begin
                            ev_valid = 1'b1;
                            ev_code  = ST_BAD_SIZE;
                        end
                    end else if (!s_tlast) begin
                        ev_valid = 1'b1;
                        ev_code  = ST_BAD_SIZE;
                    end else if (crc_valid && crc_pass && !s_tdata[31]) begin
                        ev_valid = 1'b1;
                        ev_code  = ST_SUCCESS;
                    end else begin
                        ev_valid = 1'b1;
                        ev_code  = ST_BAD_PKT;
                    end
                end
                default: begin
                    ev_valid = 1'b0;
                end
            endcase
        end
    end

    // Packet FSM: assembles the shadow register and drives registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HEADER;
            idx        <= '0;
            shadow     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            stat_valid <= 1'b0;
            stat_code  <= ST_SUCCESS;
        end else begin
            out_valid  <= 1'b0;
            stat_valid <= ev_valid;
            if (ev_valid) begin
                stat_code <= ev_code;
            end
            if (s_tvalid) begin
                case (state)
                    S_HEADER: begin
                        if (!s_tlast) begin
                            if (hdr_ok) begin
                                shadow[PRE_W-1 -: 16] <= s_tdata[15:0];
                                idx                   <= '0;
                                state                 <= S_PAYLOAD;
                            end else begin
                                state <= S_FLUSH;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (idx != LAST_IDX) begin
                            for (int i = 0; i < NWORDS - 1; i++) begin
                                if (idx == IDX_W'(i)) begin
                                    shadow[32*(NWORDS-2-i) +: 32] <= s_tdata;
                                end
                            end
                            if (s_tlast) begin
                                state <= S_HEADER;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else if (!s_tlast) begin
                            state <= S_FLUSH;
                        end else begin
                            if (ev_code == ST_SUCCESS && !inhibit) begin
                                out_valid <= 1'b1;
                                out_data  <= {shadow, ev_final};
                            end
                            state <= S_HEADER;
                        end
                    end
                    S_FLUSH: begin
                        if (s_tlast) begin
                            state <= S_HEADER;
                        end
                    end
                    default: begin
                        state <= S_HEADER;
                    end
                endcase
            end
        end
    end

    // Per-status saturating counters; clear takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_success  <= '0;
            cnt_bad_hdr  <= '0;
            cnt_bad_size <= '0;
            cnt_bad_pkt  <= '0;
        end else if (clr_counts) begin
            cnt_success  <= '0;
            cnt_bad_hdr  <= '0;
            cnt_bad_size <= '0;
            cnt_bad_pkt  <= '0;
        end else if (ev_valid) begin
            case (ev_code)
                ST_SUCCESS:  cnt_success  <= sat_inc(cnt_success);
                ST_BAD_HDR:  cnt_bad_hdr  <= sat_inc(cnt_bad_hdr);
                ST_BAD_SIZE: cnt_bad_size <= sat_inc(cnt_bad_size);
                default:     cnt_bad_pkt  <= sat_inc(cnt_bad_pkt);
            endcase
        end
    end

endmodule

// File: tb/tb_read_bpm_link_gen.sv
// Self-checking bench for read_bpm_link_gen: NWORDS=3/CNT_W=4, NWORDS=1 and
// NWORDS=8 instances share one input bus; each group of checks starts from reset.
module tb_read_bpm_link_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, crc_valid, crc_pass, inhibit, clr_counts;

    logic         ov3, sv3;
    logic [111:0] od3;
    logic [1:0]   sc3;
    logic [3:0]   cs3, ch3, cz3, cp3;

    logic         ov1, sv1;
    logic [47:0]  od1;
    logic [1:0]   sc1;
    logic [15:0]  cs1, ch1, cz1, cp1;

    logic         ov8, sv8;
    logic [271:0] od8;
    logic [1:0]   sc8;
    logic [15:0]  cs8, ch8, cz8, cp8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    read_bpm_link_gen #(.NWORDS(3), .MAGIC(16'hA5BE), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .crc_valid(crc_valid), .crc_pass(crc_pass), .inhibit(inhibit), .clr_counts(clr_counts),
        .out_valid(ov3), .out_data(od3), .stat_valid(sv3), .stat_code(sc3),
        .cnt_success(cs3), .cnt_bad_hdr(ch3), .cnt_bad_size(cz3), .cnt_bad_pkt(cp3));

    read_bpm_link_gen #(.NWORDS(1), .MAGIC(16'hA5BE), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .crc_valid(crc_valid), .crc_pass(crc_pass), .inhibit(inhibit), .clr_counts(clr_counts),
        .out_valid(ov1), .out_data(od1), .stat_valid(sv1), .stat_code(sc1),
        .cnt_success(cs1), .cnt_bad_hdr(ch1), .cnt_bad_size(cz1), .cnt_bad_pkt(cp1));

    read_bpm_link_gen #(.NWORDS(8), .MAGIC(16'hA5BE), .CNT_W(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .crc_valid(crc_valid), .crc_pass(crc_pass), .inhibit(inhibit), .clr_counts(clr_counts),
        .out_valid(ov8), .out_data(od8), .stat_valid(sv8), .stat_code(sc8),
        .cnt_success(cs8), .cnt_bad_hdr(ch8), .cnt_bad_size(cz8), .cnt_bad_pkt(cp8));

    // ctl = {stat_valid, stat_code[1:0], out_valid}; cnt = {success, bad_hdr, bad_size, bad_pkt}
    typedef struct {
        logic [31:0]  d;
        logic         v;
        logic         l;
        logic [1:0]   crc;
        logic         inh;
        logic         clr;
        logic [3:0]   ctl;
        logic [111:0] ed;
        logic [15:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic [31:0] d, input logic v, input logic l,
                                 input logic [1:0] crc, input logic inh, input logic clr,
                                 input logic [3:0] ctl, input logic [111:0] ed,
                                 input logic [15:0] cnt);
        vec_t r;
        r.d = d; r.v = v; r.l = l; r.crc = crc; r.inh = inh; r.clr = clr;
        r.ctl = ctl; r.ed = ed; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input logic ok);
        s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
        crc_valid = ok; crc_pass = ok; inhibit = 1'b0; clr_counts = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0; s_tlast = 1'b0; clr_counts = 1'b0; inhibit = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [111:0] d0, d1, d2, d3, d4, d5;
        logic [271:0] exp8;
        int np;

        d0 = '0;
        d1 = {16'h0007, 32'h11111111, 32'h22222222, 32'h3FFFFFFF};
        d2 = {16'h0123, 32'h44444444, 32'h55555555, 32'h3FFFFFFF};
        d3 = {16'h00AA, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h0CCCCCCC};
        d4 = {16'h00BB, 32'h12121212, 32'h34343434, 32'h36543210};
        d5 = {16'h00CC, 32'h00000001, 32'h00000002, 32'h00000003};

        tbl.push_back(row(32'hA5BE0007, 1, 0, 2'b00, 0, 0, 4'h0, d0, 16'h0000));
        tbl.push_back(row(32'h11111111, 1, 0, 2'b00, 0, 0, 4'h0, d0, 16'h0000));
        tbl.push_back(row(32'h22222222, 1, 0, 2'b00, 0, 0, 4'h0, d0, 16'h0000));
        tbl.push_back(row(32'h3FFFFFFF, 1, 1, 2'b11, 0, 0, 4'h9, d1, 16'h1000));
        tbl.push_back(row(32'hDEADBEEF, 0, 1, 2'b11, 0, 0, 4'h0, d1, 16'h1000));
        tbl.push_back(row(32'h12340000, 1, 0, 2'b00, 0, 0, 4'hA, d1, 16'h1100));
        tbl.push_back(row(32'hAAAAAAAA, 1, 0, 2'b00, 0, 0, 4'h2, d1, 16'h1100));
        tbl.push_back(row(32'hBBBBBBBB, 1, 0, 2'b00, 0, 0, 4'h2, d1, 16'h1100));
        tbl.push_back(row(32'hCCCCCCCC, 1, 1, 2'b00, 0, 0, 4'h2, d1, 16'h1100));
        tbl.push_back(row(32'hA5BE0123, 1, 0, 2'b00, 0, 0, 4'h2, d1, 16'h1100));
        tbl.push_back(row(32'h44444444, 1, 0, 2'b00, 0, 0, 4'h2, d1, 16'h1100));
        tbl.push_back(row(32'h55555555, 1, 0, 2'b00, 0, 0, 4'h2, d1, 16'h1100));
        tbl.push_back(row(32'h7FFFFFFF, 1, 1, 2'b11, 0, 0, 4'h9, d2, 16'h2100));
        tbl.push_back(row(32'hA5BE0001, 1, 0, 2'b00, 0, 0, 4'h0, d2, 16'h2100));
        tbl.push_back(row(32'h66666666, 1, 0, 2'b00, 0, 0, 4'h0, d2, 16'h2100));
        tbl.push_back(row(32'h77777777, 1, 1, 2'b00, 0, 0, 4'hC, d2, 16'h2110));
        tbl.push_back(row(32'hA5BE0002, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2110));
        tbl.push_back(row(32'h00000001, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2110));
        tbl.push_back(row(32'h00000002, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2110));
        tbl.push_back(row(32'h00000003, 1, 0, 2'b00, 0, 0, 4'hC, d2, 16'h2120));
        tbl.push_back(row(32'h00000004, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2120));
        tbl.push_back(row(32'h00000005, 1, 1, 2'b00, 0, 0, 4'h4, d2, 16'h2120));
        tbl.push_back(row(32'hA5BE0003, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2120));
        tbl.push_back(row(32'h00000001, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2120));
        tbl.push_back(row(32'h00000002, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h2120));
        tbl.push_back(row(32'h80000000, 1, 1, 2'b11, 0, 0, 4'hE, d2, 16'h2121));
        tbl.push_back(row(32'hA5BE0004, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2121));
        tbl.push_back(row(32'h00000001, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2121));
        tbl.push_back(row(32'h00000002, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2121));
        tbl.push_back(row(32'h00000005, 1, 1, 2'b10, 0, 0, 4'hE, d2, 16'h2122));
        tbl.push_back(row(32'hA5BE0006, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2122));
        tbl.push_back(row(32'h00000001, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2122));
        tbl.push_back(row(32'h00000002, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2122));
        tbl.push_back(row(32'h00000006, 1, 1, 2'b01, 0, 0, 4'hE, d2, 16'h2123));
        tbl.push_back(row(32'hA5BE0005, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2123));
        tbl.push_back(row(32'h00000001, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2123));
        tbl.push_back(row(32'h00000002, 1, 0, 2'b00, 0, 0, 4'h6, d2, 16'h2123));
        tbl.push_back(row(32'h00000007, 1, 1, 2'b11, 1, 0, 4'h8, d2, 16'h3123));
        tbl.push_back(row(32'hA5BE0009, 1, 1, 2'b00, 0, 0, 4'hC, d2, 16'h3133));
        tbl.push_back(row(32'hA5BE00AA, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h3133));
        tbl.push_back(row(32'hFFFFFFFF, 0, 1, 2'b11, 0, 0, 4'h4, d2, 16'h3133));
        tbl.push_back(row(32'hAAAAAAAA, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h3133));
        tbl.push_back(row(32'hBBBBBBBB, 1, 0, 2'b00, 0, 0, 4'h4, d2, 16'h3133));
        tbl.push_back(row(32'h0CCCCCCC, 1, 1, 2'b11, 0, 0, 4'h9, d3, 16'h4133));
        tbl.push_back(row(32'hA5BE00BB, 1, 0, 2'b00, 0, 0, 4'h0, d3, 16'h4133));
        tbl.push_back(row(32'h12121212, 1, 0, 2'b00, 0, 0, 4'h0, d3, 16'h4133));
        tbl.push_back(row(32'h34343434, 1, 0, 2'b00, 0, 0, 4'h0, d3, 16'h4133));
        tbl.push_back(row(32'h76543210, 1, 1, 2'b11, 0, 0, 4'h9, d4, 16'h5133));
        tbl.push_back(row(32'hA5BE00CC, 1, 0, 2'b00, 0, 0, 4'h0, d4, 16'h5133));
        tbl.push_back(row(32'h00000001, 1, 0, 2'b00, 0, 0, 4'h0, d4, 16'h5133));
        tbl.push_back(row(32'h00000002, 1, 0, 2'b00, 0, 0, 4'h0, d4, 16'h5133));
        tbl.push_back(row(32'h00000003, 1, 1, 2'b11, 0, 1, 4'h9, d5, 16'h0000));
        tbl.push_back(row(32'h00000000, 0, 0, 2'b00, 0, 0, 4'h0, d5, 16'h0000));
        tbl.push_back(row(32'h00000000, 0, 0, 2'b00, 0, 1, 4'h0, d5, 16'h0000));

        // Reset state
        rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        crc_valid = 1'b0; crc_pass = 1'b0; inhibit = 1'b0; clr_counts = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ctl", {sv3, sc3, ov3}, 4'h0);
        chk("rst_data", od3, '0);
        chk("rst_cnt", {cs3, ch3, cz3, cp3}, 16'h0000);
        rst_n = 1'b1;

        // Table-driven sequence on the NWORDS=3 instance
        for (int n = 0; n < tbl.size(); n++) begin
            vec_t t;
            t = tbl[n];
            s_tdata = t.d; s_tvalid = t.v; s_tlast = t.l;
            crc_valid = t.crc[1]; crc_pass = t.crc[0];
            inhibit = t.inh; clr_counts = t.clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ctl", n), {sv3, sc3, ov3}, t.ctl);
            chk($sformatf("vec%0d_data", n), od3, t.ed);
            chk($sformatf("vec%0d_cnt", n), {cs3, ch3, cz3, cp3}, t.cnt);
        end
        clr_counts = 1'b0; inhibit = 1'b0;

        // Counter saturation with CNT_W=4
        do_reset();
        np = 0;
        for (int p = 0; p < 17; p++) begin
            beat(32'hA5BE0000 + p, 1'b0, 1'b0);
            beat(32'h01010101, 1'b0, 1'b0);
            beat(32'h02020202, 1'b0, 1'b0);
            beat(32'h03030303, 1'b1, 1'b1);
            if (ov3) np++;
        end
        chk("sat_cnt_success", cs3, 4'hF);
        chk("sat_pulses", np, 17);
        chk("sat_other_cnts", {ch3, cz3, cp3}, 12'h000);

        // Asynchronous reset in the middle of a payload
        beat(32'hA5BE0001, 1'b0, 1'b0);
        beat(32'h11111111, 1'b0, 1'b0);
        s_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl", {sv3, sc3, ov3}, 4'h0);
        chk("midrst_data", od3, '0);
        chk("midrst_cnt", {cs3, ch3, cz3, cp3}, 16'h0000);
        @(posedge clk);
        #1;
        chk("midrst_hold_ctl", {sv3, sc3, ov3}, 4'h0);
        rst_n = 1'b1;
        beat(32'hA5BE0077, 1'b0, 1'b0);
        chk("midrst_hdr", {sv3, sc3, ov3}, 4'h0);
        beat(32'hAAAA0001, 1'b0, 1'b0);
        chk("midrst_w0", {sv3, sc3, ov3}, 4'h0);
        beat(32'hAAAA0002, 1'b0, 1'b0);
        chk("midrst_w1", {sv3, sc3, ov3}, 4'h0);
        beat(32'h00AA0003, 1'b1, 1'b1);
        chk("midrst_done_ctl", {sv3, sc3, ov3}, 4'h9);
        chk("midrst_done_data", od3, {16'h0077, 32'hAAAA0001, 32'hAAAA0002, 32'h00AA0003});

        // NWORDS=1 build
        do_reset();
        beat(32'hA5BE1234, 1'b0, 1'b0);
        chk("n1_hdr", {sv1, sc1, ov1}, 4'h0);
        beat(32'h5ABCDEF0, 1'b1, 1'b1);
        chk("n1_good_ctl", {sv1, sc1, ov1}, 4'h9);
        chk("n1_good_data", od1, 48'h1234_1ABCDEF0);
        beat(32'hA5BE0001, 1'b0, 1'b0);
        beat(32'h00000001, 1'b0, 1'b0);
        chk("n1_nolast", {sv1, sc1, ov1}, 4'hC);
        beat(32'h00000002, 1'b1, 1'b0);
        chk("n1_flush", {sv1, sc1, ov1}, 4'h4);
        beat(32'hA5BE0002, 1'b0, 1'b0);
        beat(32'h00000022, 1'b1, 1'b1);
        chk("n1_b2b_a", {sv1, sc1, ov1, od1}, {4'h9, 48'h0002_00000022});
        beat(32'hA5BE0003, 1'b0, 1'b0);
        chk("n1_b2b_gap", {sv1, ov1}, 2'b00);
        beat(32'h00000033, 1'b1, 1'b1);
        chk("n1_b2b_b", {sv1, sc1, ov1, od1}, {4'h9, 48'h0003_00000033});
        chk("n1_cnts", {cs1, ch1, cz1, cp1}, {16'd3, 16'd0, 16'd1, 16'd0});

        // NWORDS=8 build
        do_reset();
        exp8 = '0;
        exp8[271:256] = 16'h0808;
        beat(32'hA5BE0808, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            exp8[32*(7-i) +: 32] = 32'h10000000 + i;
            beat((i == 7) ? 32'h50000007 : 32'h10000000 + i, i == 7, i == 7);
            if (i < 7) chk($sformatf("n8_w%0d", i), {sv8, ov8}, 2'b00);
        end
        chk("n8_good_ctl", {sv8, sc8, ov8}, 4'h9);
        chk("n8_good_data", od8, exp8);
        beat(32'hA5BE0009, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) beat(32'h20000000 + i, 1'b0, 1'b1);
        chk("n8_nolast", {sv8, sc8, ov8}, 4'hC);
        beat(32'h20000008, 1'b1, 1'b1);
        chk("n8_flush", {sv8, sc8, ov8}, 4'h4);
        chk("n8_data_held", od8, exp8);
        chk("n8_cnts", {cs8, ch8, cz8, cp8}, {16'd1, 16'd0, 16'd1, 16'd0});

        s_tvalid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
